param_automata_engine: RTL and testbench
========================================

Name: param_automata_engine

Overview:
- Runtime-programmable homogeneous automaton of N STEs. Replaces per-pattern generated automata with one reusable engine.
- Symbol classes, adjacency, start types and report flags are loaded over a config port. Afterwards, 8-bit symbols are streamed through a valid/ready handshake.
- Each symbol cycle that activates at least one report STE pushes a report record (symbol offset, report vector) into an internal FIFO. The FIFO drains over a valid/ready output.
- Sits between the input symbol stream and the report collector of the kernel.

Parameters:
- N_STE, 8, number of STEs (2..32).
- RPT_DEPTH, 8, report FIFO depth (power of 2, at least 2).
- OFFSET_W, 32, width of the symbol offset counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe; accepted only in IDLE.
- cfg_type  in  2  0 = class slice, 1 = predecessor row, 2 = start/report attributes, 3 = reserved (write ignored).
- cfg_ste  in  $clog2(N_STE)  target STE index; writes to indices of N_STE or above are ignored.
- cfg_word  in  3  class slice select; slice k covers symbols 32k..32k+31. Used only when cfg_type = 0.
- cfg_data  in  32  type 0: class bits. Type 1: bit j = edge j->cfg_ste, bits N_STE-1:0 used. Type 2: [1:0] start type (0 none, 1 start-of-data, 2 all-input), [2] report.
- start  in  1  pulse; IDLE->RUN.
- sym_valid  in  1  symbol valid.
- sym_ready  out  1  symbol accepted when sym_valid & sym_ready.
- symbols  in  8  input symbol.
- sym_last  in  1  marks the final symbol of the stream.
- rpt_valid  out  1  report record available.
- rpt_ready  in  1  consumer pops a record when rpt_valid & rpt_ready.
- rpt_offset  out  OFFSET_W  offset of the reporting symbol.
- rpt_vector  out  N_STE  active report STEs at that symbol.
- busy  out  1  state != IDLE.
- done  out  1  single-cycle pulse on the FLUSH->IDLE transition.
- overflow  out  1  sticky; set if a report is dropped (unreachable by design, kept as an assertion hook).

Behaviour:
- Reset (asynchronous, reset = 0):
  - State = IDLE; active vector = 0; offset = 0; FIFO empty.
  - All class bits, predecessor rows and attributes cleared.
  - sym_ready, rpt_valid, busy, done and overflow = 0.
  - Reset mid-RUN aborts the stream with no done pulse.
- State machine:
  - IDLE: config writes take effect at the clock edge; start -> RUN.
  - On entering RUN: active vector = 0, offset = 0, first flag = 1.
  - RUN: accepted symbol with sym_last = 1 -> FLUSH.
  - FLUSH: FIFO empty -> IDLE, with done asserted for exactly that one cycle.
  - start is ignored outside IDLE. cfg_we is ignored outside IDLE.
- sym_ready = (state == RUN) & FIFO not full. This check is conservative: no push can ever occur when the FIFO is full.
- Per accepted symbol s:
  - enable[i] = OR over j of (pred[i][j] & active[j]) | (start = 2) | (start = 1 & first).
  - active_next[i] = enable[i] & class[i][s].
  - active, offset and first are updated at that edge; first then clears.
  - With no accepted symbol, active, offset and first hold.
- Report event: if (active_next & report_mask) != 0, push {offset of s, active_next & report_mask} at the same edge.
  - rpt_valid is high the following cycle at the earliest (show-ahead FIFO; one-cycle latency).
- FIFO:
  - Simultaneous push and pop is allowed when non-empty; the count is unchanged.
  - Pop on empty is impossible because rpt_valid = 0.
  - Records leave in push order.
- offset wraps modulo 2^OFFSET_W; no flag is raised.
- Self-loops are legal (pred[i][i]).
- A symbol accepted in RUN with sym_last = 1 is still evaluated and can report.

Test Plan:
- Pattern load: STE0 {47} start-of-data; STE1 {67,99}<-0; STE2 {68,100}<-1; STE3 {0-9,11-12,14-255}<-2,3; STE4 {24}<-2,3; STE5 {22}<-4, report.
  - Stream 47,67,100,24,22 (last on 22) -> exactly one record: offset 4, vector bit5 set. Then done pulses and busy falls.
- Same config, stream 10,47,67,100,24,22 -> no report, because start-of-data is enabled only for offset 0.
- STE0 {0x41} all-input, report, self-loop. Stream 0x41 x4 with rpt_ready = 0 and RPT_DEPTH = 2:
  - sym_ready drops after 2 records.
  - Releasing rpt_ready yields offsets 0,1,2,3 in order; overflow stays 0.
- Reset asserted during RUN mid-stream -> all outputs 0 immediately, config cleared.
  - After release, start with no config -> no reports on any stream.
- cfg_we asserted during RUN with a new class slice -> ignored; matching behaviour is unchanged versus the pre-run config.
- OFFSET_W = 4, all-input report STE matching every symbol, 18 symbols -> reported offsets 0..15, then 0, 1.

Source files
------------

// File: rtl/param_automata_engine.sv
// Runtime-programmable homogeneous automaton: N_STE state-transition elements loaded over a
// config port, fed by a symbol stream, emitting (offset, report vector) records via a FIFO.
module param_automata_engine #(
   parameter int unsigned N_STE     = 8,
   parameter int unsigned RPT_DEPTH = 8,
   parameter int unsigned OFFSET_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_we,
   input  logic [1:0]                 cfg_type,
   input  logic [$clog2(N_STE)-1:0]   cfg_ste,
   input  logic [2:0]                 cfg_word,
   input  logic [31:0]                cfg_data,
   input  logic                       start,
   input  logic                       sym_valid,
   output logic                       sym_ready,
   input  logic [7:0]                 symbols,
   input  logic                       sym_last,
   output logic                       rpt_valid,
   input  logic                       rpt_ready,
   output logic [OFFSET_W-1:0]        rpt_offset,
   output logic [N_STE-1:0]           rpt_vector,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow
);

   localparam int unsigned STE_W = $clog2(N_STE);
   localparam int unsigned PTR_W = $clog2(RPT_DEPTH);
   localparam int unsigned REC_W = OFFSET_W + N_STE;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;
   state_e state_q, state_d;

   logic [255:0]       class_q [N_STE];
   logic [N_STE-1:0]   pred_q  [N_STE];
   logic [1:0]         stype_q [N_STE];
   logic [N_STE-1:0]   rep_q;
   logic [N_STE-1:0]   active_q, active_d;
   logic [OFFSET_W-1:0] offset_q;
   logic               first_q;
   logic [REC_W-1:0]   mem_q [RPT_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]     count_q;
   logic               overflow_q;

   logic               fifo_full, fifo_empty, accept, push, push_ok, pop, cfg_en;
   logic [N_STE-1:0]   hit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PTR_W+1)'(RPT_DEPTH));
   assign accept     = sym_valid & sym_ready;
   assign hit        = active_d & rep_q;
   assign push       = accept & (|hit);
   assign push_ok    = push & ~fifo_full;
   assign pop        = rpt_valid & rpt_ready;
   assign cfg_en     = cfg_we & (state_q == S_IDLE) & ({1'b0, cfg_ste} < (STE_W+1)'(N_STE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (accept && sym_last) state_d = S_FLUSH;
         S_FLUSH: if (fifo_empty) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sym_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_RUN: begin
            sym_ready = ~fifo_full;
            busy      = 1'b1;
         end
         S_FLUSH: begin
            busy = 1'b1;
            done = fifo_empty;
         end
         default: ;
      endcase
   end

   // Start-of-data STEs are enabled only while first_q marks offset 0 of the stream.
   always_comb begin
      active_d = '0;
      for (int unsigned i = 0; i < N_STE; i++) begin
         active_d[i] = ((|(pred_q[i] & active_q)) | (stype_q[i] == 2'd2) |
                        ((stype_q[i] == 2'd1) & first_q)) & class_q[i][symbols];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_STE; i++) begin
            class_q[i] <= '0;
            pred_q[i]  <= '0;
            stype_q[i] <= '0;
         end
         rep_q <= '0;
      end else if (cfg_en) begin
         case (cfg_type)
            2'd0: class_q[cfg_ste][{cfg_word, 5'd0} +: 32] <= cfg_data;
            2'd1: pred_q[cfg_ste] <= cfg_data[N_STE-1:0];
            2'd2: begin
               stype_q[cfg_ste] <= cfg_data[1:0];
               rep_q[cfg_ste]   <= cfg_data[2];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q <= '0;
         offset_q <= '0;
         first_q  <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         active_q <= '0;
         offset_q <= '0;
         first_q  <= 1'b1;
      end else if (accept) begin
         active_q <= active_d;
         offset_q <= offset_q + OFFSET_W'(1);
         first_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {offset_q, hit};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push_ok && !pop)      count_q <= count_q + (PTR_W+1)'(1);
         else if (!push_ok && pop) count_q <= count_q - (PTR_W+1)'(1);
         if (push && fifo_full) overflow_q <= 1'b1;
      end
   end

   assign rpt_valid = ~fifo_empty;
   assign {rpt_offset, rpt_vector} = rpt_valid ? mem_q[rd_ptr_q] : '0;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_param_automata_engine.sv
// Scenario bench for param_automata_engine: expected report records are queued as symbols are
// accepted and matched against the DUT output stream.
module tb_param_automata_engine;

   localparam int N  = 8;
   localparam int D  = 2;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [1:0]    cfg_type;
   logic [2:0]    cfg_ste;
   logic [2:0]    cfg_word;
   logic [31:0]   cfg_data;
   logic          start;
   logic          sym_valid;
   logic          sym_ready;
   logic [7:0]    symbols;
   logic          sym_last;
   logic          rpt_valid;
   logic          rpt_ready;
   logic [OW-1:0] rpt_offset;
   logic [N-1:0]  rpt_vector;
   logic          busy, done, overflow;

   typedef struct packed {
      logic [OW-1:0] off;
      logic [N-1:0]  vec;
   } rec_t;

   rec_t          sb[$];
   logic [OW-1:0] exp_off;
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 clk = ~clk;

   param_automata_engine #(.N_STE(N), .RPT_DEPTH(D), .OFFSET_W(OW)) dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_type(cfg_type), .cfg_ste(cfg_ste),
      .cfg_word(cfg_word), .cfg_data(cfg_data), .start(start), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .symbols(symbols), .sym_last(sym_last), .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready), .rpt_offset(rpt_offset), .rpt_vector(rpt_vector),
      .busy(busy), .done(done), .overflow(overflow)
   );

   // Inputs change 1 ns after the rising edge, so a negedge view shows exactly the handshake.
   always @(negedge clk) begin
      rec_t e;
      if (reset && rpt_valid && rpt_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL rpt_unexpected: got off=%0d vec=%h, required no record", rpt_offset, rpt_vector);
         end else begin
            e = sb.pop_front();
            if (rpt_offset !== e.off || rpt_vector !== e.vec)
               $display("FAIL rpt_record: got off=%0d vec=%h, required off=%0d vec=%h",
                        rpt_offset, rpt_vector, e.off, e.vec);
            else n_pass++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time, required completion");
      $fatal(1);
   end

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic cfg_write(input logic [1:0] t, input logic [2:0] ste, input logic [2:0] w,
                            input logic [31:0] d);
      cfg_we = 1'b1; cfg_type = t; cfg_ste = ste; cfg_word = w; cfg_data = d;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic write_class(input logic [2:0] ste, input logic [255:0] bits);
      for (int w = 0; w < 8; w++) cfg_write(2'd0, ste, 3'(w), bits[w*32 +: 32]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
      exp_off = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      cfg_we = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; symbols = '0;
      sb.delete();
      cycle();
      reset = 1'b1;
      cycle();
   endtask

   task automatic send_sym(input logic [7:0] s, input logic last, input logic [N-1:0] exp_vec);
      rec_t r;
      bit   acc = 0;
      sym_valid = 1'b1; symbols = s; sym_last = last;
      for (int k = 0; k < 40 && !acc; k++) begin
         @(negedge clk);
         if (sym_ready) begin
            acc = 1;
            if (exp_vec != '0) begin
               r.off = exp_off; r.vec = exp_vec;
               sb.push_back(r);
            end
            exp_off++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (!acc) $display("FAIL sym_accept: symbol %0d not accepted in 40 cycles, required acceptance", s);
      else n_pass++;
   endtask

   task automatic sym_idle();
      sym_valid = 1'b0; sym_last = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      n_checks++;
      if (!seen) $display("FAIL done_pulse: done=0 after 60 cycles, required 1");
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL after_done: busy=%b done=%b, required busy=0 done=0", busy, done);
      else n_pass++;
      n_checks++;
      if (sb.size() != 0) $display("FAIL sb_drain: %0d records missing, required 0", sb.size());
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic load_pattern();
      logic [255:0] b;
      b = '0; b[47] = 1'b1;             write_class(3'd0, b);
      b = '0; b[67] = 1'b1; b[99] = 1'b1;  write_class(3'd1, b);
      b = '0; b[68] = 1'b1; b[100] = 1'b1; write_class(3'd2, b);
      b = '1; b[10] = 1'b0; b[13] = 1'b0;  write_class(3'd3, b);
      b = '0; b[24] = 1'b1;             write_class(3'd4, b);
      b = '0; b[22] = 1'b1;             write_class(3'd5, b);
      cfg_write(2'd1, 3'd1, 3'd0, 32'h01);
      cfg_write(2'd1, 3'd2, 3'd0, 32'h02);
      cfg_write(2'd1, 3'd3, 3'd0, 32'h0C);
      cfg_write(2'd1, 3'd4, 3'd0, 32'h0C);
      cfg_write(2'd1, 3'd5, 3'd0, 32'h10);
      cfg_write(2'd2, 3'd0, 3'd0, 32'h1);
      cfg_write(2'd2, 3'd5, 3'd0, 32'h4);
   endtask

   task automatic load_a_loop();
      logic [255:0] b;
      b = '0; b[8'h41] = 1'b1;
      write_class(3'd0, b);
      cfg_write(2'd1, 3'd0, 3'd0, 32'h1);
      cfg_write(2'd2, 3'd0, 3'd0, 32'h6);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cfg_we = 1'b0; cfg_type = '0; cfg_ste = '0; cfg_word = '0; cfg_data = '0;
      start = 1'b0; sym_valid = 1'b0; symbols = '0; sym_last = 1'b0; rpt_ready = 1'b0;
      cycle();
      n_checks++;
      if ({sym_ready, rpt_valid, busy, done, overflow} !== 5'b0)
         $display("FAIL reset_outputs: rdy/val/busy/done/ovf=%b, required 00000",
                  {sym_ready, rpt_valid, busy, done, overflow});
      else n_pass++;
      reset = 1'b1;
      cycle();
      n_checks++;
      if (busy !== 1'b0 || sym_ready !== 1'b0)
         $display("FAIL idle_after_reset: busy=%b sym_ready=%b, required 0 0", busy, sym_ready);
      else n_pass++;
   endtask

   task automatic test_pattern();
      apply_reset();
      load_pattern();
      rpt_ready = 1'b1;
      pulse_start();
      n_checks++;
      if (busy !== 1'b1 || sym_ready !== 1'b1)
         $display("FAIL run_entry: busy=%b sym_ready=%b, required 1 1", busy, sym_ready);
      else n_pass++;
      send_sym(8'd47, 1'b0, '0);
      send_sym(8'd67, 1'b0, '0);
      send_sym(8'd100, 1'b0, '0);
      send_sym(8'd24, 1'b0, '0);
      send_sym(8'd22, 1'b1, 8'h20);
      sym_idle();
      wait_done();
   endtask

   task automatic test_sod_only_first();
      pulse_start();
      send_sym(8'd10, 1'b0, '0);
      send_sym(8'd47, 1'b0, '0);
      send_sym(8'd67, 1'b0, '0);
      send_sym(8'd100, 1'b0, '0);
      send_sym(8'd24, 1'b0, '0);
      send_sym(8'd22, 1'b1, '0);
      sym_idle();
      wait_done();
   endtask

   task automatic test_backpressure();
      apply_reset();
      load_a_loop();
      rpt_ready = 1'b0;
      pulse_start();
      send_sym(8'h41, 1'b0, 8'h01);
      send_sym(8'h41, 1'b0, 8'h01);
      @(negedge clk);
      n_checks++;
      if (sym_ready !== 1'b0) $display("FAIL full_stall: sym_ready=%b, required 0", sym_ready);
      else n_pass++;
      n_checks++;
      if (rpt_valid !== 1'b1 || rpt_offset !== 4'd0)
         $display("FAIL show_ahead: valid=%b off=%0d, required 1 0", rpt_valid, rpt_offset);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (sym_ready !== 1'b0) $display("FAIL hold_stall: sym_ready=%b, required 0", sym_ready);
      else n_pass++;
      @(posedge clk); #1;
      rpt_ready = 1'b1;
      send_sym(8'h41, 1'b0, 8'h01);
      send_sym(8'h41, 1'b1, 8'h01);
      sym_idle();
      wait_done();
      n_checks++;
      if (overflow !== 1'b0) $display("FAIL overflow_flag: got %b, required 0", overflow);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      load_a_loop();
      rpt_ready = 1'b0;
      pulse_start();
      send_sym(8'h41, 1'b0, 8'h01);
      n_checks++;
      if (rpt_valid !== 1'b1 || busy !== 1'b1)
         $display("FAIL pre_abort: valid=%b busy=%b, required 1 1", rpt_valid, busy);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({sym_ready, rpt_valid, busy, done, overflow} !== 5'b0 || rpt_offset !== '0 || rpt_vector !== '0)
         $display("FAIL async_abort: rdy/val/busy/done/ovf=%b off=%0d vec=%h, required all 0",
                  {sym_ready, rpt_valid, busy, done, overflow}, rpt_offset, rpt_vector);
      else n_pass++;
      sb.delete();
      sym_idle();
      @(posedge clk); #1;
      reset = 1'b1;
      cycle();
      rpt_ready = 1'b1;
      pulse_start();
      send_sym(8'h41, 1'b0, '0);
      send_sym(8'h41, 1'b0, '0);
      send_sym(8'h41, 1'b1, '0);
      sym_idle();
      wait_done();
   endtask

   task automatic test_cfg_in_run();
      apply_reset();
      load_a_loop();
      rpt_ready = 1'b1;
      pulse_start();
      cfg_write(2'd0, 3'd0, 3'd1, 32'hFFFF_FFFF);
      send_sym(8'h30, 1'b0, '0);
      send_sym(8'h41, 1'b1, 8'h01);
      sym_idle();
      wait_done();
   endtask

   task automatic test_offset_wrap();
      logic [255:0] b;
      apply_reset();
      b = '1;
      write_class(3'd0, b);
      cfg_write(2'd2, 3'd0, 3'd0, 32'h6);
      rpt_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 18; k++) send_sym(8'($urandom_range(0, 255)), (k == 17), 8'h01);
      sym_idle();
      wait_done();
   endtask

   initial begin
      exp_off = '0;
      test_reset();
      test_pattern();
      test_sod_only_first();
      test_backpressure();
      test_reset_mid_run();
      test_cfg_in_run();
      test_offset_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
